// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
// Module      : memory_access
// Description : Memory stage of the interpolation ASIP. Scalar (1 beat) or
//               vector (LANES beats) load/store over a 32-bit ready-handshake
//               port, stalling EX while busy; registered results feed
//               writeback and EX forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int REG_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic                      ex_vector,
    input  logic                      ex_reg_write,
    input  logic [REG_W-1:0]          ex_rd,
    input  logic [DATA_W-1:0]         ex_alu_result,
    input  logic [DATA_W-1:0]         ex_write_data,
    input  logic [DATA_W*LANES-1:0]   ex_valu_result,
    output logic                      stall,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ready,
    output logic                      wb_valid,
    output logic                      wb_reg_write,
    output logic                      wb_vector,
    output logic [REG_W-1:0]          wb_rd,
    output logic [DATA_W-1:0]         wb_data,
    output logic [DATA_W*LANES-1:0]   wb_vdata
);

    localparam int                BEAT_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);
    localparam logic [0:0]        S_IDLE    = 1'b0;
    localparam logic [0:0]        S_BUSY    = 1'b1;

    logic [0:0]                    state_q, state_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic                          we_q, we_d;
    logic                          vec_q, vec_d;
    logic                          rw_q, rw_d;
    logic [REG_W-1:0]              rd_q, rd_d;
    logic [LANES-1:0][DATA_W-1:0]  vst_q, vst_d;
    logic [LANES-1:0][DATA_W-1:0]  lbuf_q, lbuf_d;
    logic                          mem_req_q, mem_req_d;
    logic [DATA_W-1:0]             mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]             mem_wdata_q, mem_wdata_d;
    logic                          wb_valid_q, wb_valid_d;
    logic                          wb_reg_write_q, wb_reg_write_d;
    logic                          wb_vector_q, wb_vector_d;
    logic [REG_W-1:0]              wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]             wb_data_q, wb_data_d;
    logic [LANES-1:0][DATA_W-1:0]  wb_vdata_q, wb_vdata_d;

    logic                          w_accept;
    logic                          w_last;
    logic [BEAT_W-1:0]             w_next_beat;

    assign w_accept    = ex_valid && (state_q == S_IDLE);
    assign w_last      = !vec_q || (beat_q == LAST_BEAT);
    assign w_next_beat = beat_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        we_d           = we_q;
        vec_d          = vec_q;
        rw_d           = rw_q;
        rd_d           = rd_q;
        vst_d          = vst_q;
        lbuf_d         = lbuf_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_vector_d    = wb_vector_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        wb_vdata_d     = wb_vdata_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (ex_mem_read || ex_mem_write) begin
                        // A set read bit wins over write; stores never write a register
                        state_d     = S_BUSY;
                        beat_d      = '0;
                        mem_req_d   = 1'b1;
                        we_d        = ex_mem_write && !ex_mem_read;
                        vec_d       = ex_vector;
                        rw_d        = ex_mem_read ? ex_reg_write : 1'b0;
                        rd_d        = ex_rd;
                        vst_d       = ex_valu_result;
                        mem_addr_d  = {ex_alu_result[DATA_W-1:2], 2'b00};
                        mem_wdata_d = ex_vector ? ex_valu_result[DATA_W-1:0] : ex_write_data;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = ex_reg_write;
                        wb_vector_d    = ex_vector;
                        wb_rd_d        = ex_rd;
                        wb_data_d      = ex_alu_result;
                        wb_vdata_d     = ex_valu_result;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        if (vec_q) lbuf_d[beat_q] = mem_rdata;
                        else       wb_data_d      = mem_rdata;
                    end
                    if (w_last) begin
                        state_d        = S_IDLE;
                        mem_req_d      = 1'b0;
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = rw_q;
                        wb_vector_d    = vec_q;
                        wb_rd_d        = rd_q;
                        // Vector loads publish all lanes together at retirement
                        if (!we_q && vec_q) wb_vdata_d = lbuf_d;
                    end else begin
                        beat_d      = w_next_beat;
                        mem_addr_d  = mem_addr_q + DATA_W'(4);
                        mem_wdata_d = vst_q[w_next_beat];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            beat_q         <= '0;
            we_q           <= 1'b0;
            vec_q          <= 1'b0;
            rw_q           <= 1'b0;
            rd_q           <= '0;
            vst_q          <= '0;
            lbuf_q         <= '0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_vector_q    <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            wb_vdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            we_q           <= we_d;
            vec_q          <= vec_d;
            rw_q           <= rw_d;
            rd_q           <= rd_d;
            vst_q          <= vst_d;
            lbuf_q         <= lbuf_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_vector_q    <= wb_vector_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            wb_vdata_q     <= wb_vdata_d;
        end
    end

    assign stall        = (state_q == S_BUSY);
    assign mem_req      = mem_req_q;
    assign mem_we       = we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_vector    = wb_vector_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_vdata     = wb_vdata_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access
// Description : Self-checking bench for memory_access: instruction table,
//               memory responder with wait states, writeback scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access;

    logic         clk = 1'b0;
    logic         rst;
    logic         ex_valid, ex_mem_read, ex_mem_write, ex_vector, ex_reg_write;
    logic [3:0]   ex_rd;
    logic [31:0]  ex_alu_result, ex_write_data;
    logic [127:0] ex_valu_result;
    logic         stall, mem_req, mem_we;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic         mem_ready;
    logic         wb_valid, wb_reg_write, wb_vector;
    logic [3:0]   wb_rd;
    logic [31:0]  wb_data;
    logic [127:0] wb_vdata;

    always #5 clk = ~clk;

    memory_access #(.DATA_W(32), .LANES(4), .REG_W(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_vector(ex_vector), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
        .ex_valu_result(ex_valu_result),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_vector(wb_vector),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_vdata(wb_vdata)
    );

    typedef struct {
        logic         rd_;
        logic         wr;
        logic         vec;
        logic         rw;
        logic [3:0]   rd;
        logic [31:0]  alu;
        logic [31:0]  wdata;
        logic [127:0] valu;
        logic [127:0] rdata;
        int           waits;
        int           exp_lat;
        logic         exp_rw;
        logic [31:0]  exp_data;
        logic [127:0] exp_vdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } beat_t;

    typedef struct {
        logic         rw;
        logic         vec;
        logic [3:0]   rd;
        logic         chk_data;
        logic [31:0]  data;
        logic         chk_vdata;
        logic [127:0] vdata;
    } wbexp_t;

    beat_t  beats[$];
    wbexp_t wbs[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Last architecturally defined writeback values
    logic [31:0]  m_d;
    logic [127:0] m_v;
    bit           m_dk, m_vk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    function automatic vec_t mk(input logic rd_, input logic wr, input logic vec, input logic rw,
                                input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] wdata,
                                input logic [127:0] valu, input logic [127:0] rdata, input int waits,
                                input int lat, input logic exp_rw, input logic [31:0] exp_data,
                                input logic [127:0] exp_vdata);
        vec_t v;
        v.rd_ = rd_; v.wr = wr; v.vec = vec; v.rw = rw; v.rd = rd;
        v.alu = alu; v.wdata = wdata; v.valu = valu; v.rdata = rdata; v.waits = waits;
        v.exp_lat = lat; v.exp_rw = exp_rw; v.exp_data = exp_data; v.exp_vdata = exp_vdata;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1. Pushes expected beats and retirement.
    task automatic issue(input vec_t v, input bit wait_wb, output int stalls);
        wbexp_t      e;
        bit          mem, ld;
        int          lat, busy;
        logic [31:0] p_d;
        logic [127:0] p_v;
        bit          p_dk, p_vk;
        mem = v.rd_ | v.wr;
        ld  = v.rd_;
        p_d = m_d; p_v = m_v; p_dk = m_dk; p_vk = m_vk;
        ex_valid = 1'b1; ex_mem_read = v.rd_; ex_mem_write = v.wr; ex_vector = v.vec;
        ex_reg_write = v.rw; ex_rd = v.rd; ex_alu_result = v.alu;
        ex_write_data = v.wdata; ex_valu_result = v.valu;
        if (mem) begin
            for (int i = 0; i < (v.vec ? 4 : 1); i++) begin
                beat_t b;
                b.we    = v.wr & ~v.rd_;
                b.addr  = {v.alu[31:2], 2'b00} + 32'(4 * i);
                b.wdata = v.vec ? v.valu[32*i +: 32] : v.wdata;
                b.rdata = v.rdata[32*i +: 32];
                b.waits = v.waits;
                beats.push_back(b);
            end
        end
        e.rw = v.exp_rw; e.vec = v.vec; e.rd = v.rd;
        e.chk_data = 1'b0; e.data = '0; e.chk_vdata = 1'b0; e.vdata = '0;
        if (!mem) begin
            e.chk_data = 1'b1; e.data = v.exp_data; e.chk_vdata = 1'b1; e.vdata = v.exp_vdata;
            m_d = v.exp_data; m_v = v.exp_vdata; m_dk = 1; m_vk = 1;
        end else if (ld && !v.vec) begin
            e.chk_data = 1'b1; e.data = v.exp_data; e.chk_vdata = m_vk; e.vdata = m_v;
            m_d = v.exp_data; m_dk = 1;
        end else if (ld) begin
            e.chk_vdata = 1'b1; e.vdata = v.exp_vdata;
            m_v = v.exp_vdata; m_vk = 1; m_dk = 0;
        end else begin
            m_dk = 0; m_vk = 0;
        end
        wbs.push_back(e);
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 60) begin fail_now("accept timeout"); break; end
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (wait_wb) begin
            lat = 0; busy = 0;
            forever begin
                @(negedge clk);
                lat++;
                if (stall) busy++;
                if (wb_valid) break;
                if (p_dk) check("hold wb_data", wb_data, p_d);
                if (p_vk) check("hold wb_vdata", wb_vdata, p_v);
                if (lat > 60) begin fail_now("wb timeout"); break; end
            end
            check("latency", lat, v.exp_lat);
            check("stall cycles", busy, v.exp_lat - 1);
            @(posedge clk); #1;
        end
    endtask

    // Memory responder: checks each presented beat, answers after 'waits' idle cycles
    initial begin
        int    wc;
        beat_t b;
        mem_ready = 1'b0; mem_rdata = '0; wc = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!rst) begin
                wc = 0;
            end else if (mem_req) begin
                if (beats.size() == 0) begin
                    fail_now("unexpected mem_req");
                end else begin
                    b = beats[0];
                    check("mem_addr", mem_addr, b.addr);
                    check("mem_we", mem_we, b.we);
                    if (b.we) check("mem_wdata", mem_wdata, b.wdata);
                    if (wc < b.waits) begin
                        wc++;
                    end else begin
                        mem_ready = 1'b1;
                        mem_rdata = b.rdata;
                        void'(beats.pop_front());
                        wc = 0;
                    end
                end
            end
        end
    end

    // Writeback monitor
    initial begin
        wbexp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (wbs.size() == 0) begin
                    fail_now("unexpected wb_valid");
                end else begin
                    e = wbs.pop_front();
                    check("wb_reg_write", wb_reg_write, e.rw);
                    check("wb_vector", wb_vector, e.vec);
                    check("wb_rd", wb_rd, e.rd);
                    if (e.chk_data)  check("wb_data", wb_data, e.data);
                    if (e.chk_vdata) check("wb_vdata", wb_vdata, e.vdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t tv;
        int   st;
        bit   found;

        tbl[0] = mk(0,0,0,1, 4'd3,  32'd1234,      32'h0, 128'hABCD, 128'h0, 0, 1, 1, 32'd1234, 128'hABCD);
        tbl[1] = mk(0,0,1,0, 4'd15, 32'hFFFF_FFFF, 32'h1, {4{32'hA5A5_5A5A}}, 128'h0, 0, 1, 0,
                    32'hFFFF_FFFF, {4{32'hA5A5_5A5A}});
        tbl[2] = mk(1,0,0,1, 4'd5,  32'h103,       32'h0, 128'h0, 128'd9999, 2, 4, 1, 32'd9999, 128'h0);
        tbl[3] = mk(0,1,1,1, 4'd7,  32'h200,       32'h0, {32'h4444, 32'h3333, 32'h2222, 32'h1111},
                    128'h0, 0, 5, 0, 32'h0, 128'h0);
        tbl[4] = mk(0,1,0,1, 4'd2,  32'h7,         32'hDEAD_BEEF, 128'h0, 128'h0, 1, 3, 0, 32'h0, 128'h0);
        tbl[5] = mk(1,0,1,1, 4'd8,  32'hFFFF_FFF8, 32'h0, 128'h0, {32'd4, 32'd3, 32'd2, 32'd1},
                    0, 5, 1, 32'h0, {32'd4, 32'd3, 32'd2, 32'd1});
        tbl[6] = mk(1,1,0,1, 4'd9,  32'h40,        32'h1234_5678, 128'h0, 128'h55AA, 0, 2, 1, 32'h55AA, 128'h0);
        tbl[7] = mk(1,0,1,1, 4'd10, 32'h1000,      32'h0, 128'h1, {32'hD, 32'hC, 32'hB, 32'hA},
                    1, 9, 1, 32'h0, {32'hD, 32'hC, 32'hB, 32'hA});

        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_vector = 0; ex_reg_write = 0;
        ex_rd = '0; ex_alu_result = '0; ex_write_data = '0; ex_valu_result = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset stall", stall, 0);
        check("reset mem_req", mem_req, 0);
        check("reset wb_valid", wb_valid, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset wb_data", wb_data, 0);
        check("reset wb_vdata", wb_vdata, 0);
        m_d = '0; m_v = '0; m_dk = 1; m_vk = 1;
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i], 1, st);
            check("accept without stall", st, 0);
        end

        // Back-to-back: ALU op held on ex_valid while a scalar load is busy
        tv = mk(1,0,0,1, 4'd6, 32'h500, 32'h0, 128'h0, 128'h77, 1, 3, 1, 32'h77, 128'h0);
        issue(tv, 0, st);
        tv = mk(0,0,0,1, 4'd13, 32'h4242, 32'h0, 128'h4242, 128'h0, 0, 1, 1, 32'h4242, 128'h4242);
        issue(tv, 1, st);
        check("b2b stall cycles", st, 2);

        // Reset asserted during beat 2 of a vector load
        tv = mk(1,0,1,1, 4'd11, 32'h300, 32'h0, 128'h0, {32'h4, 32'h3, 32'h2, 32'h1}, 5, 0, 1, 32'h0, 128'h0);
        issue(tv, 0, st);
        found = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h308) begin found = 1; break; end
        end
        check("beat 2 reached", found, 1);
        #2 rst = 1'b0;
        beats.delete();
        wbs.delete();
        #1;
        check("async reset mem_req", mem_req, 0);
        check("async reset stall", stall, 0);
        check("async reset wb_valid", wb_valid, 0);
        @(negedge clk);
        check("reset mem_addr after abort", mem_addr, 0);
        check("reset wb_vdata after abort", wb_vdata, 0);
        m_d = '0; m_v = '0; m_dk = 1; m_vk = 1;
        @(posedge clk); #1 rst = 1'b1;
        tv = mk(0,0,0,1, 4'd12, 32'h5555, 32'h0, 128'h99, 128'h0, 0, 1, 1, 32'h5555, 128'h99);
        issue(tv, 1, st);
        check("accept after reset", st, 0);

        repeat (3) @(negedge clk);
        check("wb scoreboard drained", wbs.size(), 0);
        check("beat scoreboard drained", beats.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
